// File: rtl/pram_xfer_ctrl_if.sv
// rtl/pram_xfer_ctrl_if.sv - host command/stream and bank-array signal bundle for pram_xfer_ctrl
interface pram_xfer_ctrl_if #(
   parameter int CELL_N    = 10,
   parameter int D_LEN     = 16,
   parameter int DA_AWIDTH = 8,
   parameter int DW_AWIDTH = 10,
   parameter int LWIDTH    = DW_AWIDTH + 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_op;
   logic                  cmd_tgt;
   logic [DW_AWIDTH-1:0]  cmd_base;
   logic [LWIDTH-1:0]     cmd_len;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [D_LEN-1:0]      wr_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [D_LEN-1:0]      rd_data;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [CELL_N-1:0]     da_wen;
   logic [CELL_N-1:0]     dw_wen;
   logic [DA_AWIDTH-1:0]  da_addr;
   logic [DW_AWIDTH-1:0]  dw_addr;
   logic [CELL_N-1:0]     da_sel;
   logic [CELL_N-1:0]     dw_sel;
   logic [D_LEN-1:0]      da_din;
   logic [D_LEN-1:0]      dw_din;
   logic [D_LEN-1:0]      da_dout;
   logic [D_LEN-1:0]      dw_dout;

   modport slave (
      input  cmd_valid, cmd_op, cmd_tgt, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
             da_dout, dw_dout,
      output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err, da_wen, dw_wen,
             da_addr, dw_addr, da_sel, dw_sel, da_din, dw_din
   );

   modport master (
      output cmd_valid, cmd_op, cmd_tgt, cmd_base, cmd_len, wr_valid, wr_data, rd_ready,
             da_dout, dw_dout,
      input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err, da_wen, dw_wen,
             da_addr, dw_addr, da_sel, dw_sel, da_din, dw_din
   );
endinterface

// File: rtl/pram_xfer_ctrl.sv
// rtl/pram_xfer_ctrl.sv - scatter/gather transfer controller for the DA/DW bank arrays
module pram_xfer_ctrl #(
   parameter int CELL_N    = 10,
   parameter int D_LEN     = 16,
   parameter int DA_AWIDTH = 8,
   parameter int DW_AWIDTH = 10,
   parameter int LWIDTH    = DW_AWIDTH + 4
) (
   input  logic              clk,
   input  logic              rst_n,
   pram_xfer_ctrl_if.slave   bus
);
   localparam int CW   = (CELL_N > 1) ? $clog2(CELL_N) : 1;
   localparam int CAPW = DW_AWIDTH + 6;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CHECK    = 3'd1;
   localparam logic [2:0] S_WR       = 3'd2;
   localparam logic [2:0] S_RD_ISSUE = 3'd3;
   localparam logic [2:0] S_RD_DATA  = 3'd4;
   localparam logic [2:0] S_FIN      = 3'd5;

   logic [2:0]           state_q, state_d;
   logic                 op_q, op_d;
   logic                 tgt_q, tgt_d;
   logic [DW_AWIDTH-1:0] base_q, base_d;
   logic [DW_AWIDTH-1:0] row_q, row_d;
   logic [LWIDTH-1:0]    len_q, len_d;
   logic [LWIDTH-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]        cell_q, cell_d;

   logic [CAPW-1:0]      avail_rows;
   logic [CAPW-1:0]      cap_words;
   logic                 reject;
   logic                 advance;
   logic                 last_word;
   logic [CELL_N-1:0]    cell_oh;
   logic [CELL_N-1:0]    wen_v;
   logic [CELL_N-1:0]    sel_v;
   logic                 st_wr, st_rdi, st_rdd, bank_act;

   assign cell_oh   = {{(CELL_N-1){1'b0}}, 1'b1} << cell_q;
   assign last_word = (cnt_q == len_q - LWIDTH'(1));

   // Range check without a divider: ceil(len/N) rows fit iff len <= free_rows * N.
   always_comb begin
      if (tgt_q) avail_rows = (CAPW'(1) << DW_AWIDTH) - CAPW'(base_q);
      else       avail_rows = (CAPW'(1) << DA_AWIDTH) - CAPW'(base_q);
      cap_words = avail_rows * CAPW'(CELL_N);
      reject    = (len_q == '0) || (CAPW'(len_q) > cap_words);
      if (!tgt_q && ((base_q >> DA_AWIDTH) != '0)) reject = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      tgt_d   = tgt_q;
      base_d  = base_q;
      len_d   = len_q;
      row_d   = row_q;
      cell_d  = cell_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               tgt_d   = bus.cmd_tgt;
               base_d  = bus.cmd_base;
               len_d   = bus.cmd_len;
               row_d   = bus.cmd_base;
               cell_d  = '0;
               cnt_d   = '0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (reject)    state_d = S_IDLE;
            else if (op_q) state_d = S_RD_ISSUE;
            else           state_d = S_WR;
         end
         S_WR: begin
            if (bus.wr_valid) begin
               advance = 1'b1;
               if (last_word) state_d = S_FIN;
            end
         end
         S_RD_ISSUE: state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (bus.rd_ready) begin
               advance = 1'b1;
               state_d = last_word ? S_FIN : S_RD_ISSUE;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (advance) begin
         cnt_d = cnt_q + LWIDTH'(1);
         if (cell_q == CW'(CELL_N - 1)) begin
            cell_d = '0;
            row_d  = row_q + DW_AWIDTH'(1);
         end else begin
            cell_d = cell_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         tgt_q   <= 1'b0;
         base_q  <= '0;
         len_q   <= '0;
         row_q   <= '0;
         cell_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         tgt_q   <= tgt_d;
         base_q  <= base_d;
         len_q   <= len_d;
         row_q   <= row_d;
         cell_q  <= cell_d;
         cnt_q   <= cnt_d;
      end
   end

   assign st_wr    = (state_q == S_WR);
   assign st_rdi   = (state_q == S_RD_ISSUE);
   assign st_rdd   = (state_q == S_RD_DATA);
   assign bank_act = st_wr || st_rdi || st_rdd;

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_FIN);
   assign bus.err       = (state_q == S_CHECK) && reject;
   assign bus.wr_ready  = st_wr;
   assign bus.rd_valid  = st_rdd;
   assign bus.rd_data   = st_rdd ? (tgt_q ? bus.dw_dout : bus.da_dout) : '0;

   // Only the addressed region ever sees activity; the other stays fully quiet.
   assign wen_v       = (st_wr && bus.wr_valid) ? cell_oh : '0;
   assign sel_v       = (st_rdi || st_rdd) ? cell_oh : '0;
   assign bus.dw_wen  = tgt_q ? wen_v : '0;
   assign bus.da_wen  = tgt_q ? '0 : wen_v;
   assign bus.dw_sel  = tgt_q ? sel_v : '0;
   assign bus.da_sel  = tgt_q ? '0 : sel_v;
   assign bus.dw_addr = (bank_act && tgt_q) ? row_q : '0;
   assign bus.da_addr = (bank_act && !tgt_q) ? row_q[DA_AWIDTH-1:0] : '0;
   assign bus.dw_din  = (st_wr && tgt_q) ? bus.wr_data : '0;
   assign bus.da_din  = (st_wr && !tgt_q) ? bus.wr_data : '0;
endmodule

// File: tb/tb_pram_xfer_ctrl.sv
// tb/tb_pram_xfer_ctrl.sv - directed scoreboard bench for pram_xfer_ctrl
module tb_pram_xfer_ctrl;
   localparam int CELL_N    = 10;
   localparam int D_LEN     = 16;
   localparam int DA_AWIDTH = 8;
   localparam int DW_AWIDTH = 10;
   localparam int LWIDTH    = DW_AWIDTH + 4;

   typedef struct packed {
      logic                 tgt;
      logic [DW_AWIDTH-1:0] addr;
      logic [CELL_N-1:0]    oh;
      logic [D_LEN-1:0]     data;
   } wr_exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;
   int   err_cnt  = 0;

   wr_exp_t          wr_q[$];
   logic [D_LEN-1:0] rd_q[$];
   wr_exp_t          mon_e;

   logic [D_LEN-1:0] da_mem    [CELL_N][1<<DA_AWIDTH];
   logic [D_LEN-1:0] dw_mem    [CELL_N][1<<DW_AWIDTH];
   logic [D_LEN-1:0] da_shadow [CELL_N][1<<DA_AWIDTH];
   logic [D_LEN-1:0] dw_shadow [CELL_N][1<<DW_AWIDTH];

   pram_xfer_ctrl_if #(.CELL_N(CELL_N), .D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH),
                       .DW_AWIDTH(DW_AWIDTH), .LWIDTH(LWIDTH)) bus ();

   pram_xfer_ctrl #(.CELL_N(CELL_N), .D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH),
                    .DW_AWIDTH(DW_AWIDTH), .LWIDTH(LWIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Bank array: per-cell write, registered one-hot-selected read.
   always @(posedge clk) begin
      bus.da_dout <= '0;
      bus.dw_dout <= '0;
      for (int c = 0; c < CELL_N; c++) begin
         if (bus.da_wen[c]) da_mem[c][bus.da_addr] <= bus.da_din;
         if (bus.dw_wen[c]) dw_mem[c][bus.dw_addr] <= bus.dw_din;
         if (bus.da_sel[c]) bus.da_dout <= da_mem[c][bus.da_addr];
         if (bus.dw_sel[c]) bus.dw_dout <= dw_mem[c][bus.dw_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CELL_N-1:0] onehot(input int c);
      logic [CELL_N-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   // Write scoreboard: every wen pulse must match the next expected word.
   always @(negedge clk) begin
      if (!rst_n) begin
         if (bus.done) done_cnt++;
         if (bus.err)  err_cnt++;
         if (|bus.da_wen || |bus.dw_wen) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_wen", {12'h0, bus.da_wen, bus.dw_wen}, 32'h0);
            end else begin
               mon_e = wr_q.pop_front();
               if (mon_e.tgt) begin
                  chk("dw_wen", bus.dw_wen, mon_e.oh);
                  chk("dw_addr", bus.dw_addr, mon_e.addr);
                  chk("dw_din", bus.dw_din, mon_e.data);
                  chk("da_quiet", {bus.da_wen, bus.da_addr}, 0);
               end else begin
                  chk("da_wen", bus.da_wen, mon_e.oh);
                  chk("da_addr", bus.da_addr, mon_e.addr);
                  chk("da_din", bus.da_din, mon_e.data);
                  chk("dw_quiet", {bus.dw_wen, bus.dw_addr}, 0);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic op, input logic tgt, input int base, input int len);
      chk("cmd_ready_before", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_tgt   = tgt;
      bus.cmd_base  = DW_AWIDTH'(base);
      bus.cmd_len   = LWIDTH'(len);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_sig(input bit rd, output int waits);
      waits = 0;
      while ((rd ? !bus.rd_valid : !bus.wr_ready) && waits < 20) begin
         tick();
         waits++;
      end
   endtask

   task automatic do_write(input logic tgt, input int base, input int len,
                           input bit gaps, input bit poke);
      int               waits, d0;
      wr_exp_t          e;
      logic [D_LEN-1:0] data;
      d0 = done_cnt;
      send_cmd(1'b0, tgt, base, len);
      wait_sig(1'b0, waits);
      chk("wr_latency", waits + 1, 2);
      for (int k = 0; k < len; k++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            bus.wr_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         if (poke && k == 5) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 1'b1;
         end
         data         = D_LEN'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_data  = data;
         e.tgt  = tgt;
         e.addr = DW_AWIDTH'(base + k / CELL_N);
         e.oh   = onehot(k % CELL_N);
         e.data = data;
         wr_q.push_back(e);
         if (tgt) dw_shadow[k % CELL_N][base + k / CELL_N] = data;
         else     da_shadow[k % CELL_N][base + k / CELL_N] = data;
         tick();
         bus.cmd_valid = 1'b0;
      end
      bus.wr_valid = 1'b0;
      chk("wr_done_pulse", bus.done, 1);
      tick();
      chk("wr_done_once", done_cnt - d0, 1);
      chk("wr_ready_after", bus.cmd_ready, 1);
      chk("wr_q_drained", wr_q.size(), 0);
   endtask

   task automatic do_read(input logic tgt, input int base, input int len, input bit stall);
      int               waits, d0;
      logic [D_LEN-1:0] exp, held;
      d0 = done_cnt;
      send_cmd(1'b1, tgt, base, len);
      for (int k = 0; k < len; k++)
         rd_q.push_back(tgt ? dw_shadow[k % CELL_N][base + k / CELL_N]
                            : da_shadow[k % CELL_N][base + k / CELL_N]);
      for (int k = 0; k < len; k++) begin
         wait_sig(1'b1, waits);
         if (k == 0) chk("rd_latency", waits + 1, 3);
         chk("rd_valid", bus.rd_valid, 1);
         chk("rd_sel", tgt ? bus.dw_sel : bus.da_sel, onehot(k % CELL_N));
         chk("rd_addr", tgt ? 32'(bus.dw_addr) : 32'(bus.da_addr), base + k / CELL_N);
         exp = rd_q.pop_front();
         if (stall && (k % 2 == 1)) begin
            held = bus.rd_data;
            tick();
            chk("rd_hold_valid", bus.rd_valid, 1);
            chk("rd_hold_data", bus.rd_data, held);
         end
         chk("rd_data", bus.rd_data, exp);
         bus.rd_ready = 1'b1;
         tick();
         bus.rd_ready = 1'b0;
      end
      chk("rd_done_pulse", bus.done, 1);
      tick();
      chk("rd_done_once", done_cnt - d0, 1);
   endtask

   task automatic do_err(input logic tgt, input int base, input int len);
      int e0;
      e0 = err_cnt;
      bus.wr_valid = 1'b1;
      send_cmd(1'b0, tgt, base, len);
      chk("err_pulse", bus.err, 1);
      chk("err_ready_low", bus.cmd_ready, 0);
      tick();
      bus.wr_valid = 1'b0;
      chk("err_ready_back", bus.cmd_ready, 1);
      chk("err_cleared", bus.err, 0);
      chk("err_once", err_cnt - e0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits, d0;
      wr_exp_t e;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'b0;
      bus.cmd_tgt   = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.rd_ready  = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done_err", {bus.done, bus.err}, 0);
      chk("rst_wr_rd", {bus.wr_ready, bus.rd_valid, bus.rd_data}, 0);
      chk("rst_wen", {bus.da_wen, bus.dw_wen}, 0);
      chk("rst_sel_addr", {bus.da_sel, bus.dw_sel, bus.da_addr}, 0);
      chk("rst_dw_addr", bus.dw_addr, 0);
      rst_n = 1'b0;
      tick();

      do_write(1'b1, 5, 23, 1'b0, 1'b0);
      do_read(1'b1, 5, 23, 1'b1);

      do_err(1'b0, 250, 80);
      do_err(1'b1, 5, 0);
      do_err(1'b0, 256, 1);
      do_err(1'b1, 1022, 21);

      do_write(1'b1, 1022, 20, 1'b0, 1'b0);
      do_read(1'b1, 1022, 20, 1'b0);
      do_write(1'b0, 250, 60, 1'b1, 1'b0);

      do_write(1'b0, 3, 10, 1'b1, 1'b1);
      do_read(1'b0, 3, 10, 1'b1);

      d0 = done_cnt;
      send_cmd(1'b0, 1'b1, 100, 12);
      wait_sig(1'b0, waits);
      for (int k = 0; k < 4; k++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = D_LEN'($urandom);
         e.tgt  = 1'b1;
         e.addr = DW_AWIDTH'(100);
         e.oh   = onehot(k);
         e.data = bus.wr_data;
         wr_q.push_back(e);
         dw_shadow[k][100] = bus.wr_data;
         tick();
      end
      rst_n        = 1'b1;
      bus.wr_valid = 1'b1;
      #1;
      chk("abort_wen", bus.dw_wen, 0);
      chk("abort_idle", {bus.busy, bus.cmd_ready}, 2'b01);
      bus.wr_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_q_drained", wr_q.size(), 0);

      do_write(1'b0, 0, 12, 1'b0, 1'b0);
      do_read(1'b0, 0, 12, 1'b0);
      do_read(1'b1, 100, 4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pram_xfer_ctrl.md
# pram_xfer_ctrl

Transfer controller for the parallel activation/weight RAM bank array. It accepts one command at a time from the host-side loader. It then either scatters a stream of D_LEN-bit words across the CELL_N banks of the DA or DW region, or gathers them back into a stream. It drives the bank array's per-cell write enables, shared address and one-hot read select, so the host never handles bank geometry.

## Interface
- CELL_N, 10, number of banks per region (2..16)
- D_LEN, 16, word width
- DA_AWIDTH, 8, DA bank address width; DA depth = 2^DA_AWIDTH
- DW_AWIDTH, 10, DW bank address width; DW depth = 2^DW_AWIDTH (DW_AWIDTH ≥ DA_AWIDTH)
- LWIDTH, DW_AWIDTH+4, command length width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = write (load), 1 = read (dump)
- cmd_tgt  in  1  0 = DA region, 1 = DW region
- cmd_base  in  DW_AWIDTH  starting bank address
- cmd_len  in  LWIDTH  word count
- wr_valid / wr_ready  in / out  1  write-stream handshake
- wr_data  in  D_LEN  write word
- rd_valid / rd_ready  out / in  1  read-stream handshake
- rd_data  out  D_LEN  read word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, command completed
- err  out  1  one-cycle pulse, command rejected
- da_wen, dw_wen  out  CELL_N  one-hot write enables
- da_addr  out  DA_AWIDTH; dw_addr  out  DW_AWIDTH  shared bank address
- da_sel, dw_sel  out  CELL_N  one-hot read select
- da_din, dw_din  out  D_LEN  write data (= wr_data)
- da_dout, dw_dout  in  D_LEN  selected bank read data; registered read, valid one cycle after address

## Operation
- Word k of a command maps to cell c = k mod CELL_N, row r = cmd_base + k div CELL_N. Counters hold (row, cell); cell wraps CELL_N-1 → 0 with row+1. No divider.
- States: IDLE, CHECK, WR, RD_ISSUE, RD_DATA, FIN.
- IDLE: on cmd_valid, latch op/tgt/base/len, zero the counters, go to CHECK.
- CHECK (1 cycle): rows = ceil(len/CELL_N). Reject if len = 0, or base + rows − 1 > depth − 1 of the target region. For DA, nonzero base bits above DA_AWIDTH also cause rejection. On reject, pulse err and go to IDLE with no bank access. Otherwise go to WR (op 0) or RD_ISSUE (op 1).
- WR: wr_ready = 1. On wr_valid, the target region's wen = onehot(cell), addr = row, din = wr_data, all combinational in that cycle. Advance the counters. After the len-th handshake go to FIN.
- RD_ISSUE: drive addr = row, sel = onehot(cell), then go to RD_DATA.
- RD_DATA: hold addr/sel. rd_valid = 1, rd_data = target dout. On rd_ready, advance the counters; go to FIN after the len-th word, else to RD_ISSUE.
- FIN: pulse done, go to IDLE.
- The non-target region sees wen = 0, sel = 0 and addr = 0 throughout. wen is never asserted outside WR.
- Commands are never queued. cmd_valid while busy is ignored.

## Timing
- Reset values: state IDLE; cmd_ready 1; all other outputs 0.
- Reset mid-command aborts at once (asynchronous). No done or err is issued. A partially written region keeps the words already written.
- Write throughput is 1 word/cycle. Command accept → first wr_ready = 2 cycles (IDLE→CHECK→WR).
- Read throughput is 1 word per 2 cycles. First rd_valid comes 3 cycles after command accept.
- rd_data/rd_valid stay stable while rd_ready is low. wr_valid low simply stalls the counters.
- done asserts the cycle after the last handshake. err asserts the cycle after accept. cmd_ready returns the cycle after done/err.

## Test plan
- Write DW, base 5, len 23, wr_valid always high → 23 consecutive dw_wen pulses: 0x001..0x200 at addr 5, same at addr 6, 0x001..0x004 at addr 7; done exactly once; da_wen stays 0.
- Read back the same command with rd_ready toggling 1,0,1,0 → rd_data matches the written sequence in order; rd_data held stable during stalls; dw_sel one-hot matching the cell.
- DA, base 250, len 80 (8 rows, last row 257 > 255) → err pulse, zero wen activity, cmd_ready high 2 cycles after accept. Also len = 0 → err.
- Write DA, len 10, with wr_valid gaps of random length → exactly 10 wen pulses, all at addr = base, cell order 0..9.
- Assert rst_n = 1 after 4 of 12 write words → wen drops the same cycle; no done. A fresh write command accepted after reset runs correctly from cell 0.
- cmd_valid pulsed while busy → ignored; exactly one done per accepted command.
